// File: rtl/ip_rx_arbiter.sv
// Round-robin, frame-granular arbiter sharing the IP receive header checker
// between two 16-bit frame sources; a watchdog force-ends stalled frames.
module ip_rx_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd2048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic        sof0,
    input  logic        sof1,
    input  logic        eof0,
    input  logic        eof1,
    input  logic        valid0,
    input  logic        valid1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic        ipsof,
    output logic        ipeof,
    output logic        ipvalidin,
    output logic [15:0] ipdatain,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  frame_cnt0,
    output logic [7:0]  frame_cnt1
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

    state_t      state, state_next;
    logic        last_winner, last_winner_next;
    logic [15:0] idle_cnt, idle_cnt_next;
    logic        sof_next, eof_next, valid_next, terr_next;
    logic [15:0] data_next;
    logic [7:0]  cnt0_next, cnt1_next;
    logic        sel_valid, sel_sof, sel_eof;
    logic [15:0] sel_data;

    assign gnt0 = (state == GRANT0);
    assign gnt1 = (state == GRANT1);
    assign busy = (state != IDLE);

    always_comb begin
        state_next       = state;
        last_winner_next = last_winner;
        idle_cnt_next    = idle_cnt;
        sof_next         = 1'b0;
        eof_next         = 1'b0;
        valid_next       = 1'b0;
        terr_next        = 1'b0;
        data_next        = ipdatain;
        cnt0_next        = frame_cnt0;
        cnt1_next        = frame_cnt1;

        sel_valid = valid0;
        sel_sof   = sof0;
        sel_eof   = eof0;
        sel_data  = data0;
        if (state == GRANT1) begin
            sel_valid = valid1;
            sel_sof   = sof1;
            sel_eof   = eof1;
            sel_data  = data1;
        end

        case (state)
            IDLE: begin
                // On a tie the source that did not win last time is served.
                if (req0 && (!req1 || last_winner)) begin
                    state_next       = GRANT0;
                    last_winner_next = 1'b0;
                    idle_cnt_next    = '0;
                end else if (req1) begin
                    state_next       = GRANT1;
                    last_winner_next = 1'b1;
                    idle_cnt_next    = '0;
                end
            end
            GRANT0, GRANT1: begin
                if (sel_valid) begin
                    valid_next    = 1'b1;
                    sof_next      = sel_sof;
                    eof_next      = sel_eof;
                    data_next     = sel_data;
                    idle_cnt_next = '0;
                    if (sel_eof) begin
                        state_next = GAP;
                        if (state == GRANT0) cnt0_next = frame_cnt0 + 8'd1;
                        else                 cnt1_next = frame_cnt1 + 8'd1;
                    end
                end else if (idle_cnt == TIMEOUT) begin
                    // Forced eof closes the frame downstream without counting it.
                    valid_next    = 1'b1;
                    eof_next      = 1'b1;
                    data_next     = '0;
                    terr_next     = 1'b1;
                    idle_cnt_next = '0;
                    state_next    = GAP;
                end else begin
                    idle_cnt_next = idle_cnt + 16'd1;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            idle_cnt    <= '0;
            ipsof       <= 1'b0;
            ipeof       <= 1'b0;
            ipvalidin   <= 1'b0;
            ipdatain    <= '0;
            timeout_err <= 1'b0;
            frame_cnt0  <= '0;
            frame_cnt1  <= '0;
        end else begin
            state       <= state_next;
            last_winner <= last_winner_next;
            idle_cnt    <= idle_cnt_next;
            ipsof       <= sof_next;
            ipeof       <= eof_next;
            ipvalidin   <= valid_next;
            ipdatain    <= data_next;
            timeout_err <= terr_next;
            frame_cnt0  <= cnt0_next;
            frame_cnt1  <= cnt1_next;
        end
    end

endmodule

// File: tb/tb_ip_rx_arbiter.sv
// Scoreboard bench for ip_rx_arbiter: drivers push expected beats and grant
// order, a negedge monitor pops and compares whatever the DUT emits.
module tb_ip_rx_arbiter;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        sof0 = 1'b0, sof1 = 1'b0, eof0 = 1'b0, eof1 = 1'b0;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic [15:0] data0 = '0, data1 = '0;
    logic        gnt0, gnt1, ipsof, ipeof, ipvalidin, busy, timeout_err;
    logic [15:0] ipdatain;
    logic [7:0]  frame_cnt0, frame_cnt1;

    ip_rx_arbiter #(.TIMEOUT(16'd8)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .sof0(sof0), .sof1(sof1), .eof0(eof0), .eof1(eof1),
        .valid0(valid0), .valid1(valid1), .data0(data0), .data1(data1),
        .ipsof(ipsof), .ipeof(ipeof), .ipvalidin(ipvalidin), .ipdatain(ipdatain),
        .busy(busy), .timeout_err(timeout_err),
        .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    logic [18:0] exp_q[$];      // {sof, eof, timeout_err, data}
    int          exp_gnt[$];
    int          model_last;
    logic [7:0]  model_cnt [2];
    bit          tie_mode = 1'b0;
    bit          noise_on = 1'b0;
    int          cyc = 0;
    int          last_vld_cyc = 0;
    int          last_eof_cyc = 0;
    bit          have_eof = 1'b0;
    bit          pg0 = 1'b0, pg1 = 1'b0;
    logic [15:0] ip_words [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic grant_seen(input int s);
        if (exp_gnt.size() == 0) begin
            errors++; checks++;
            $display("FAIL grant_order: unexpected grant to source %0d", s);
        end else begin
            check("grant_order", 32'(s), 32'(exp_gnt.pop_front()));
        end
        if (have_eof) begin
            if (tie_mode) check("turnaround", 32'(cyc - last_eof_cyc), 32'd2);
            else begin
                checks++;
                if (cyc - last_eof_cyc < 2) begin
                    errors++;
                    $display("FAIL turnaround_min: got %0d cycles expected >= 2", cyc - last_eof_cyc);
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clock);
        cyc++;
        if (reset) begin
            pg0 = 1'b0; pg1 = 1'b0; have_eof = 1'b0;
        end else begin
            if (gnt0 && gnt1) begin
                errors++; checks++;
                $display("FAIL gnt_exclusive: gnt0=%b gnt1=%b", gnt0, gnt1);
            end
            if (gnt0 && !pg0) grant_seen(0);
            if (gnt1 && !pg1) grant_seen(1);
            pg0 = gnt0; pg1 = gnt1;
            if (ipvalidin) begin
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_beat: sof=%b eof=%b data=%h", ipsof, ipeof, ipdatain);
                end else begin
                    logic [18:0] e;
                    e = exp_q.pop_front();
                    check("beat", {13'd0, ipsof, ipeof, timeout_err, ipdatain}, {13'd0, e});
                    if (e[16]) check("timeout_latency", 32'(cyc - last_vld_cyc), 32'(TO + 1));
                end
                last_vld_cyc = cyc;
                if (ipeof) begin last_eof_cyc = cyc; have_eof = 1'b1; end
            end else begin
                check("idle_strobes", {29'd0, ipsof, ipeof, timeout_err}, 32'd0);
            end
        end
    end

    function automatic logic gnt_of(input int src);
        return (src == 0) ? gnt0 : gnt1;
    endfunction

    function automatic logic [7:0] cnt_of(input int src);
        return (src == 0) ? frame_cnt0 : frame_cnt1;
    endfunction

    task automatic set_req(input int src, input logic r);
        if (src == 0) req0 = r; else req1 = r;
    endtask

    task automatic drive(input int src, input logic v, input logic s, input logic e, input logic [15:0] d);
        if (src == 0) begin valid0 = v; sof0 = s; eof0 = e; data0 = d; end
        else          begin valid1 = v; sof1 = s; eof1 = e; data1 = d; end
    endtask

    // to_after >= 0: send that many words without eof and expect a forced end.
    task automatic send_frame(input int src, input int nwords, input int maxgap,
                              input bit directed, input int to_after);
        int          waited, n_send, g;
        logic [15:0] w;
        logic        s, e;
        w = '0;
        set_req(src, 1'b1);
        waited = 0;
        do begin @(posedge clock); #1; waited++; end
        while (!gnt_of(src) && waited < 3000);
        if (!gnt_of(src)) begin
            errors++; checks++;
            $display("FAIL grant_wait: source %0d not granted in %0d cycles", src, waited);
            set_req(src, 1'b0);
            return;
        end
        if (directed) check("grant_latency", 32'(waited), 32'd1);
        n_send = (to_after >= 0) ? to_after : nwords;
        for (int i = 0; i < n_send; i++) begin
            g = $urandom_range(maxgap, 0);
            repeat (g) begin
                drive(src, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
                @(posedge clock); #1;
            end
            w = directed ? ip_words[i] : 16'($urandom);
            s = (i == 0);
            e = (to_after < 0) && (i == nwords - 1);
            drive(src, 1'b1, s, e, w);
            exp_q.push_back({s, e, 1'b0, w});
            @(posedge clock); #1;
        end
        drive(src, 1'b0, 1'b0, 1'b0, w);
        if (to_after >= 0) exp_q.push_back({1'b0, 1'b1, 1'b1, 16'h0000});
        else               model_cnt[src] = model_cnt[src] + 8'd1;
        waited = 0;
        while (gnt_of(src) && waited < TO + 10) begin @(posedge clock); #1; waited++; end
        if (gnt_of(src)) begin
            errors++; checks++;
            $display("FAIL release_wait: source %0d still granted after %0d cycles", src, waited);
        end
        set_req(src, 1'b0);
        check("frame_cnt", 32'(cnt_of(src)), 32'(model_cnt[src]));
        @(posedge clock); #1;
        check("busy_after_gap", 32'(busy), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt_busy"}, {29'd0, gnt1, gnt0, busy}, 32'd0);
        check({tag, "_strobes"}, {28'd0, ipvalidin, ipsof, ipeof, timeout_err}, 32'd0);
        check({tag, "_data"}, {16'd0, ipdatain}, 32'd0);
        check({tag, "_cnts"}, {16'd0, frame_cnt1, frame_cnt0}, 32'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_gnt.delete();
        model_last   = 1;
        model_cnt[0] = '0;
        model_cnt[1] = '0;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit");
    end

    initial begin
        int waited, src, nw, mg, to, first;
        ip_words = '{16'h4500, 16'h001C, 16'h0001, 16'h0000, 16'h4011,
                     16'h0000, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h0002};
        model_reset();
        #1 reset = 1'b1;
        #2 check_idle_outputs("reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Tie from reset: 0, then 1, then 0 again.
        tie_mode = 1'b1;
        exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0);
        model_last = 0;
        fork
            begin send_frame(0, 4, 2, 1'b0, -1); send_frame(0, 3, 2, 1'b0, -1); end
            begin send_frame(1, 5, 2, 1'b0, -1); end
        join
        tie_mode = 1'b0;

        // Directed IPv4 header words, no gaps.
        exp_gnt.push_back(0); model_last = 0;
        send_frame(0, 10, 0, 1'b1, -1);

        // Timeout on source 1 after sof plus two words.
        exp_gnt.push_back(1); model_last = 1;
        send_frame(1, 3, 0, 1'b0, 3);

        // Isolation: noise with 0xDEAD on source 1 while source 0 is granted.
        exp_gnt.push_back(0); model_last = 0;
        noise_on = 1'b1;
        fork
            begin send_frame(0, 10, 3, 1'b0, -1); noise_on = 1'b0; end
            begin
                while (noise_on) begin
                    valid1 = 1'($urandom); sof1 = 1'($urandom); eof1 = 1'($urandom);
                    data1 = 16'hDEAD;
                    @(posedge clock); #1;
                end
                valid1 = 1'b0; sof1 = 1'b0; eof1 = 1'b0;
            end
        join
        check("isolation_cnt1", 32'(frame_cnt1), 32'(model_cnt[1]));

        // One-word frames on both sources.
        exp_gnt.push_back(1); model_last = 1;
        send_frame(1, 1, 0, 1'b0, -1);
        exp_gnt.push_back(0); model_last = 0;
        send_frame(0, 1, 0, 1'b0, -1);

        // Random sequential frames, gaps up to TO-1, occasional timeouts.
        for (int k = 0; k < 20; k++) begin
            src = $urandom_range(1, 0);
            nw  = $urandom_range(12, 1);
            mg  = $urandom_range(TO - 1, 0);
            to  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(3, 1)) : -1;
            exp_gnt.push_back(src); model_last = src;
            send_frame(src, nw, mg, 1'b0, to);
        end

        // Random simultaneous requests resolved by round-robin.
        tie_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            first = (model_last == 1) ? 0 : 1;
            exp_gnt.push_back(first); exp_gnt.push_back(1 - first);
            model_last = 1 - first;
            fork
                send_frame(0, $urandom_range(8, 1), $urandom_range(TO - 1, 0), 1'b0,
                           ($urandom_range(4, 0) == 0) ? 2 : -1);
                send_frame(1, $urandom_range(8, 1), $urandom_range(TO - 1, 0), 1'b0, -1);
            join
        end
        tie_mode = 1'b0;

        // Reset while word 4 of a frame is on the input.
        exp_gnt.push_back(0);
        req0 = 1'b1;
        waited = 0;
        do begin @(posedge clock); #1; waited++; end
        while (!gnt0 && waited < 100);
        if (!gnt0) begin
            errors++; checks++;
            $display("FAIL grant_wait: source 0 not granted before reset test");
        end
        for (int i = 0; i < 4; i++) begin
            logic [15:0] w;
            logic        s;
            w = 16'($urandom) | 16'h0001;
            s = (i == 0);
            drive(0, 1'b1, s, 1'b0, w);
            exp_q.push_back({s, 1'b0, 1'b0, w});
            @(posedge clock); #1;
        end
        drive(0, 1'b1, 1'b0, 1'b0, 16'h1234);
        #2 reset = 1'b1;
        #1 check_idle_outputs("midframe_reset");
        model_reset();
        req0 = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(posedge clock); #1;
        check_idle_outputs("held_reset");
        reset = 1'b0;

        exp_gnt.push_back(1); model_last = 1;
        send_frame(1, 5, 3, 1'b0, -1);

        // 256 one-word frames wrap frame_cnt0.
        for (int k = 0; k < 256; k++) begin
            exp_gnt.push_back(0); model_last = 0;
            send_frame(0, 1, 0, 1'b0, -1);
        end
        check("wrap_cnt0", 32'(frame_cnt0), 32'(model_cnt[0]));

        repeat (3) @(posedge clock);
        #1;
        check("beats_drained", 32'(exp_q.size()), 32'd0);
        check("grants_drained", 32'(exp_gnt.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
